// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronised, edge-detected buttons drive an IDLE/RUN/PAUSED/DONE
// FSM and a tick divider that paces an external two-digit counter. All outputs are registered.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       ending,
  output logic       cnt_en,
  output logic       cnt_pause,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       done
);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_e;

  localparam int               DIV_W    = 26;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam int               B_PAUSE  = 0;
  localparam int               B_START  = 1;
  localparam int               B_CLR    = 2;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [2:0]       arm_q, arm_d, btn_edge;
  logic [1:0]       fill_q, fill_d;
  logic             end_q, end_d, end_p_q, end_p_d;
  logic [1:0]       clr_h_q, clr_h_d;
  logic             init_q;
  logic             cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  logic             cnt_pause_q, cnt_pause_d, done_q, done_d;
  logic             clr_edge_nxt, end_rise, tick_d;

  // A button is armed only once its synchroniser has held a genuine low sample
  // after reset, so a button held through reset never yields an edge.
  always_comb begin
    sync1_d      = {btn_clr, btn_start, btn_pause};
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    fill_d       = {fill_q[0], 1'b1};
    arm_d        = arm_q | ({3{fill_q[1]}} & ~sync2_q);
    btn_edge     = sync2_q & ~sync3_q & arm_q;
    clr_edge_nxt = sync1_q[B_CLR] & ~sync2_q[B_CLR] & arm_d[B_CLR];
    end_d        = ending;
    end_p_d      = end_q;
    clr_h_d      = {clr_h_q[0], cnt_clr_q};
    end_rise     = end_q & ~end_p_q & ~(|clr_h_q);
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_clr_d = 1'b0;
    if (init_q) begin
      state_d   = IDLE;
      div_d     = '0;
      cnt_clr_d = 1'b1;
    end else if (btn_edge[B_CLR]) begin
      state_d   = IDLE;
      div_d     = '0;
      cnt_clr_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          div_d = '0;
          if (btn_edge[B_START]) state_d = RUN;
        end
        RUN: begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
          if (end_rise) begin
            state_d = DONE;
            div_d   = '0;
          end else if (btn_edge[B_PAUSE] && !btn_edge[B_START]) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (btn_edge[B_START] || btn_edge[B_PAUSE]) state_d = RUN;
        end
        DONE: begin
          div_d = '0;
          if (btn_edge[B_START]) begin
            state_d   = RUN;
            cnt_clr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A tick right before a clear pulse is dropped so cnt_en never doubles up.
    tick_d      = (state_d == RUN) && (div_d == DIV_LAST) && ((TICK_DIV == 1) || !clr_edge_nxt);
    cnt_en_d    = cnt_clr_d | tick_d;
    cnt_pause_d = (state_d != RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      arm_q       <= '0;
      fill_q      <= '0;
      end_q       <= 1'b0;
      end_p_q     <= 1'b0;
      clr_h_q     <= '0;
      init_q      <= 1'b1;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      cnt_pause_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      arm_q       <= arm_d;
      fill_q      <= fill_d;
      end_q       <= end_d;
      end_p_q     <= end_p_d;
      clr_h_q     <= clr_h_d;
      init_q      <= 1'b0;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      cnt_pause_q <= cnt_pause_d;
      done_q      <= done_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign cnt_pause = cnt_pause_q;
  assign state     = state_q;
  assign done      = done_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4 driving a behavioural two-digit counter;
// table of button/expectation records plus hand-written pause, wrap and reset sequences.
module tb_stopwatch_ctrl;
  localparam int TD = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_clr = 1'b0;
  logic       ending_m = 1'b0;
  logic       cnt_en, cnt_pause, cnt_clr, done;
  logic [1:0] state;
  int         cnt_m = 55;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .CLK(CLK), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause), .btn_clr(btn_clr),
    .ending(ending_m), .cnt_en(cnt_en), .cnt_pause(cnt_pause), .cnt_clr(cnt_clr),
    .state(state), .done(done)
  );

  always #5 CLK = ~CLK;

  // Two-digit counter: clear wins, counts on cnt_en unless held, flags wrap/clear on ending.
  always @(posedge CLK) begin
    if (cnt_clr) begin
      cnt_m    <= 0;
      ending_m <= 1'b1;
    end else if (cnt_en && !cnt_pause) begin
      if (cnt_m == 99) begin
        cnt_m    <= 0;
        ending_m <= 1'b1;
      end else begin
        cnt_m    <= cnt_m + 1;
        ending_m <= 1'b0;
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  int clr_seen = 0, since_tick = 0;
  bit prev_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (cnt_clr) clr_seen++;
    chk("done_iff_DONE", int'(done), int'(state == 2'b11));
    chk("pause_iff_not_RUN", int'(cnt_pause), int'(state != 2'b01));
    chk("clr_needs_en", int'(cnt_clr & ~cnt_en), 0);
    chk("en_not_back_to_back", int'(cnt_en & prev_en), 0);
    prev_en = cnt_en;
    if (cnt_en) since_tick = 0;
    else if (state == 2'b01) since_tick++;
  endtask

  task automatic press(input bit s, input bit p, input bit c);
    btn_start = s;
    btn_pause = p;
    btn_clr   = c;
    step();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
  endtask

  typedef struct {
    bit s; bit p; bit c;
    int wait_n; int exp_state; int exp_cnt; int exp_clrs;
  } vec_t;
  typedef struct { int idx; int exp_state; int exp_cnt; int exp_clrs; } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];
  sb_t  e;
  int   h, n;
  bit   seen;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // {start, pause, clr, cycles after press, state, counter, clear pulses}
    vecs[0] = '{0, 1, 0,  6, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 23, 1, 5, 0};
    vecs[2] = '{1, 0, 0,  8, 1, 7, 0};
    vecs[3] = '{0, 0, 1,  6, 0, 0, 1};
    vecs[4] = '{1, 0, 0, 11, 1, 2, 0};
    vecs[5] = '{0, 1, 0, 40, 2, 2, 0};
    vecs[6] = '{0, 1, 0, 12, 1, 5, 0};
    vecs[7] = '{1, 1, 1,  6, 0, 0, 1};
    vecs[8] = '{1, 0, 0,  7, 1, 1, 0};

    step();
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_cnt_pause", int'(cnt_pause), 1);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    step();
    chk("post_rst_clr", int'(cnt_clr), 1);
    chk("post_rst_en", int'(cnt_en), 1);
    step();
    chk("post_rst_clr_off", int'(cnt_clr), 0);
    chk("post_rst_cnt", cnt_m, 0);
    chk("post_rst_state", int'(state), 0);

    for (int i = 0; i < 9; i++) begin
      clr_seen = 0;
      sbq.push_back('{i, vecs[i].exp_state, vecs[i].exp_cnt, vecs[i].exp_clrs});
      press(vecs[i].s, vecs[i].p, vecs[i].c);
      for (int k = 1; k < vecs[i].wait_n; k++) step();
      e = sbq.pop_front();
      chk($sformatf("vec%0d_state", e.idx), int'(state), e.exp_state);
      chk($sformatf("vec%0d_count", e.idx), cnt_m, e.exp_cnt);
      chk($sformatf("vec%0d_clr_pulses", e.idx), clr_seen, e.exp_clrs);
    end

    // Pause at 37, hold 40 cycles, resume: tick phase must carry over.
    for (int k = 0; k < 400 && cnt_m != 37; k++) step();
    chk("reach_37", cnt_m, 37);
    press(0, 1, 0);
    for (int k = 0; k < 6 && state != 2'b10; k++) step();
    chk("pause_state", int'(state), 2);
    h = since_tick;
    for (int k = 0; k < 40; k++) step();
    chk("paused_count", cnt_m, 37);
    chk("paused_hold", int'(cnt_pause), 1);
    press(0, 1, 0);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (state == 2'b01) n++;
      if (cnt_en) seen = 1'b1;
    end
    chk("resume_tick_seen", int'(seen), 1);
    chk("resume_phase", n, TD - h);
    step();
    chk("resume_count", cnt_m, 38);

    // Wrap 99 -> 00 ends in DONE; restart clears and must not fall back into DONE.
    for (int k = 0; k < 1000 && cnt_m != 99; k++) step();
    chk("reach_99", cnt_m, 99);
    for (int k = 0; k < 20 && state != 2'b11; k++) step();
    chk("wrap_state", int'(state), 3);
    chk("wrap_done", int'(done), 1);
    chk("wrap_count", cnt_m, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cnt_en) n++;
    end
    chk("done_no_en", n, 0);
    chk("done_stays", int'(state), 3);
    clr_seen = 0;
    press(1, 0, 0);
    for (int k = 1; k < 30; k++) step();
    chk("restart_clr_pulses", clr_seen, 1);
    chk("restart_state", int'(state), 1);
    chk("restart_count", cnt_m, 6);

    // Reset at 42 with start held: abort, clear once, no RUN until a fresh press.
    for (int k = 0; k < 400 && cnt_m != 42; k++) step();
    chk("reach_42", cnt_m, 42);
    btn_start = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrun_rst_state", int'(state), 0);
    chk("midrun_rst_en", int'(cnt_en), 0);
    chk("midrun_rst_pause", int'(cnt_pause), 1);
    rst = 1'b0;
    step();
    chk("midrun_rel_clr", int'(cnt_clr), 1);
    chk("midrun_rel_en", int'(cnt_en), 1);
    step();
    chk("midrun_rel_count", cnt_m, 0);
    for (int k = 0; k < 12; k++) step();
    chk("held_btn_no_run", int'(state), 0);
    btn_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    press(1, 0, 0);
    for (int k = 0; k < 8 && state != 2'b01; k++) step();
    chk("fresh_press_run", int'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLK cycles per count tick (legal range 1 to 2^26).
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn_start  input  1  start/resume request, level from a push button, asynchronous to CLK.
REQ-005 btn_pause  input  1  pause/resume toggle request, asynchronous to CLK.
REQ-006 btn_clr  input  1  clear request, asynchronous to CLK.
REQ-007 ending  input  1  wrap flag from the two-digit counter; 1 after the counter wraps 99->0 or is cleared.
REQ-008 cnt_en  output  1  counter enable; one-cycle pulses only.
REQ-009 cnt_pause  output  1  counter hold request.
REQ-010 cnt_clr  output  1  counter clear request; one-cycle pulse, always coincident with cnt_en=1.
REQ-011 state  output  2  FSM state: IDLE=00, RUN=01, PAUSED=10, DONE=11.
REQ-012 done  output  1  1 exactly when state==DONE.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; a button that rises before posedge k SHALL affect state at posedge k+2 and never more than once per press.
REQ-014 Command priority within one cycle SHALL be clr > start > pause; lower-priority edges in that cycle are discarded.
REQ-015 A clr edge in any state SHALL move to IDLE, zero the divider, and drive cnt_clr=cnt_en=1 for exactly one cycle.
REQ-016 IDLE: start edge -> RUN with divider=0; pause edge ignored.
REQ-017 RUN: pause edge -> PAUSED; qualified ending rise (REQ-021) -> DONE; start edge ignored.
REQ-018 PAUSED: start or pause edge -> RUN, divider resumes from its held value (tick phase preserved).
REQ-019 DONE: start edge -> RUN with one cnt_clr=cnt_en=1 pulse and divider=0 (restart from 00); pause edge ignored.
REQ-020 Divider: counts 0..TICK_DIV-1 only in RUN, wraps to 0; cnt_en=1 for one cycle in RUN when divider==TICK_DIV-1; held in PAUSED; 0 in IDLE/DONE.
REQ-021 ending SHALL be registered; a 0->1 transition qualifies only in RUN and only if cnt_clr was 0 in the previous 2 cycles; ending held at 1 SHALL not retrigger.
REQ-022 cnt_pause SHALL be 0 in RUN, 1 in IDLE, PAUSED and DONE.
REQ-023 If a qualified ending rise and a pause edge occur in the same cycle, DONE SHALL win.
REQ-024 cnt_en SHALL be 1 only on tick cycles (REQ-020) or clear cycles (REQ-015, REQ-019, REQ-027); never two consecutive cycles except with TICK_DIV=1.
REQ-025 TICK_DIV=1 SHALL produce cnt_en=1 on every RUN cycle.
REQ-026 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-027 While rst=1 at posedge: state=IDLE, divider=0, synchronizers and edge registers=0, ending register=0, cnt_en=0, cnt_clr=0, cnt_pause=1, done=0; on the first posedge with rst=0 the block SHALL issue one cnt_clr=cnt_en=1 pulse to zero the counter.
REQ-028 rst asserted mid-RUN or mid-clear pulse SHALL abort immediately to the REQ-027 values at that posedge; buttons held through reset SHALL not generate edges after release of rst.

Verification (TICK_DIV=4, counter model attached)
REQ-029 rst 2 cycles, release -> cnt_clr=cnt_en=1 for 1 cycle, state=00, counter=00.
REQ-030 start pulse -> state=01 two cycles later; cnt_en pulses every 4th cycle; counter reaches 05 after 20 RUN cycles.
REQ-031 pause at count 37, wait 40 cycles, pause again -> count stays 37, state=10 then 01, next cnt_en exactly (4 - phase held) cycles after resume.
REQ-032 run to 99 -> next tick wraps to 00, ending rises, state=11, done=1, cnt_en stays 0; start -> clear pulse, state=01, no false DONE from clr-induced ending.
REQ-033 start, pause and clr rising together in RUN -> state=00, single cnt_clr pulse, counter=00, pause ignored.
REQ-034 rst asserted for 1 cycle at count 42 in RUN with btn_start held high -> state=00, clear pulse after release, no RUN until btn_start released and pressed again.
